hex_word_scroller: RTL and testbench
====================================

Name: hex_word_scroller

Overview:
- Parametrised, clocked successor to the 3-digit "dE1" rotator.
- Holds a WORD_LEN-character word in an internal buffer and shows a NUM_DISP-digit window of it on the 7-segment displays.
- The window rotates automatically at a programmable tick rate, or one position per manual step, in either direction.
- Sits between the board top level (SW/KEY/CLOCK_50) and the HEX outputs.

Parameters:
- NUM_DISP, 6: number of 7-seg digits driven (1..6).
- WORD_LEN, 8: characters in the word buffer (2..16).
- TICK_DIV, 50000000: clock cycles per auto-rotate tick (>=1; 1 = tick every cycle).

Ports:
- Clock  in  1  system clock (CLOCK_50 at top level).
- Reset  in  1  synchronous, active-high reset.
- Load  in  1  1-cycle pulse: capture Word_In into the buffer.
- Word_In  in  3*WORD_LEN  character codes; char j = Word_In[3j+2:3j]; char 0 shows leftmost at offset 0.
- Run  in  1  1 = auto-rotate on tick.
- Dir  in  1  0 = offset +1 (text scrolls left); 1 = offset -1 (scrolls right).
- Step  in  1  1-cycle pulse: advance one position; honoured only when Run=0.
- HEX  out  7*NUM_DISP  active-low segments; digit k = HEX[7k+6:7k], bit order g..a; k=0 is the rightmost digit.
- Offset  out  clog2(WORD_LEN)  current rotation position.
- Wrap  out  1  1-cycle pulse when Offset wraps.

Behaviour:
- Character codes and segments (g..a, active-low):
  - 0 'd' = 0100001
  - 1 'E' = 0000110
  - 2 '1' = 1111001
  - 3 '0' = 1000000
  - 4 'H' = 0001001
  - 5 'L' = 1000111
  - 6 'P' = 0001100
  - 7 blank = 1111111
- Reset (synchronous, overrides everything):
  - buffer = all code 7;
  - Offset = 0, tick counter = 0, Wrap = 0;
  - HEX = all 1s on the cycle after Reset is sampled.
  - Reset asserted mid-rotation aborts immediately. No pending tick or step survives.
- Tick counter:
  - counts 0..TICK_DIV-1 every cycle, regardless of Run;
  - tick = (count == TICK_DIV-1), then the counter wraps to 0.
- Advance event = (Run & tick) | (~Run & Step). Step while Run=1 is ignored.
  - Dir=0: Offset <= (Offset==WORD_LEN-1) ? 0 : Offset+1.
  - Dir=1: Offset <= (Offset==0) ? WORD_LEN-1 : Offset-1.
- Wrap:
  - registered; 1 for exactly the cycle after an advance that crosses WORD_LEN-1->0 (Dir=0) or 0->WORD_LEN-1 (Dir=1); else 0.
- Load:
  - buffer <= Word_In, Offset <= 0, tick counter <= 0, Wrap <= 0.
  - Load has priority over a same-cycle advance; that advance is discarded.
- Display mapping:
  - digit k shows buffer[(Offset + NUM_DISP-1-k) mod WORD_LEN].
  - WORD_LEN < NUM_DISP makes the word repeat across digits.
  - The mod is computed with compare/subtract, no divider; no index may run out of range.
- HEX latency: HEX is registered from the current buffer/Offset, so it reflects any buffer or Offset change exactly 1 cycle after that change.
- Offset width: clog2(WORD_LEN), minimum 1. Offset values >= WORD_LEN are unreachable.

Test Plan:
1. Reset held 2 cycles -> Offset=0, Wrap=0, HEX all 1s on following cycle; stays so with Run=0 and no Step.
2. NUM_DISP=3, WORD_LEN=3, Load {2,1,0} ("dE1"), Run=0 -> HEX2/1/0 = 0100001/0000110/1111001. Step x1 -> "E1d"; Step x1 -> "1dE"; Step x1 -> "dE1" with Wrap=1 for one cycle.
3. TICK_DIV=4, WORD_LEN=8, Run=1, Dir=0 -> Offset advances every 4 cycles: 0,1,...,7,0. Wrap pulses once per 32 cycles. HEX lags Offset by 1 cycle.
4. Same config, Dir=1 from Offset=0 -> next tick gives Offset=7 and Wrap=1. Step pulses while Run=1 change nothing.
5. Load asserted on the same cycle as a tick at Offset=5 -> Offset=0, counter restarts (next tick 4 cycles later), new word displayed 1 cycle after Load.
6. NUM_DISP=6, WORD_LEN=2, Load {1,4} ("HE") -> digits 5..0 show H,E,H,E,H,E. One Step -> E,H,E,H,E,H with Wrap=0. Second Step -> H,E,... with Wrap=1.

Source files
------------

// File: rtl/hex_word_scroller_if.sv
// Control and display bundle between the board top level and hex_word_scroller.
// The master modport drives the controls; the slave modport returns segments, offset and wrap.
interface hex_word_scroller_if #(
  parameter int NUM_DISP = 6,
  parameter int WORD_LEN = 8
) ();
  localparam int OFF_W = (WORD_LEN > 2) ? $clog2(WORD_LEN) : 1;

  logic                    Load;
  logic [3*WORD_LEN-1:0]   Word_In;
  logic                    Run;
  logic                    Dir;
  logic                    Step;
  logic [7*NUM_DISP-1:0]   HEX;
  logic [OFF_W-1:0]        Offset;
  logic                    Wrap;

  modport master (
    output Load, Word_In, Run, Dir, Step,
    input  HEX, Offset, Wrap
  );

  modport slave (
    input  Load, Word_In, Run, Dir, Step,
    output HEX, Offset, Wrap
  );
endinterface

// File: rtl/hex_word_scroller.sv
// Rotating 7-segment word display: a WORD_LEN-character buffer viewed through a
// NUM_DISP-digit window that advances on a divided tick or on manual steps.
module hex_word_scroller #(
  parameter int NUM_DISP = 6,
  parameter int WORD_LEN = 8,
  parameter int TICK_DIV = 50000000
) (
  input  logic              Clock,
  input  logic              Reset,
  hex_word_scroller_if.slave bus
);
  localparam int OFF_W = (WORD_LEN > 2) ? $clog2(WORD_LEN) : 1;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = 6;
  localparam int RED_N = 1 + (NUM_DISP - 1) / WORD_LEN;
  localparam logic [2:0] BLANK = 3'd7;

  logic [2:0]            buf_q [WORD_LEN];
  logic [2:0]            buf_d [WORD_LEN];
  logic [OFF_W-1:0]      offset_q, offset_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wrap_q, wrap_d;
  logic [7*NUM_DISP-1:0] hex_q, hex_d;
  logic                  tick;
  logic                  adv;
  logic [IDX_W-1:0]      idx;
  logic [2:0]            ch;

  function automatic logic [6:0] seg7(input logic [2:0] code);
    logic [6:0] s;
    case (code)
      3'd0:    s = 7'b0100001;
      3'd1:    s = 7'b0000110;
      3'd2:    s = 7'b1111001;
      3'd3:    s = 7'b1000000;
      3'd4:    s = 7'b0001001;
      3'd5:    s = 7'b1000111;
      3'd6:    s = 7'b0001100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (cnt_q == CNT_W'(TICK_DIV - 1));
    adv      = bus.Run ? tick : bus.Step;
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    offset_d = offset_q;
    wrap_d   = 1'b0;
    buf_d    = buf_q;
    if (adv) begin
      if (!bus.Dir) begin
        if (offset_q == OFF_W'(WORD_LEN - 1)) begin
          offset_d = '0;
          wrap_d   = 1'b1;
        end else begin
          offset_d = offset_q + OFF_W'(1);
        end
      end else begin
        if (offset_q == '0) begin
          offset_d = OFF_W'(WORD_LEN - 1);
          wrap_d   = 1'b1;
        end else begin
          offset_d = offset_q - OFF_W'(1);
        end
      end
    end
    // A load wins over any advance landing on the same cycle.
    if (bus.Load) begin
      for (int j = 0; j < WORD_LEN; j++) buf_d[j] = bus.Word_In[3*j +: 3];
      offset_d = '0;
      cnt_d    = '0;
      wrap_d   = 1'b0;
    end
  end

  always_comb begin
    hex_d = '0;
    idx   = '0;
    ch    = BLANK;
    for (int k = 0; k < NUM_DISP; k++) begin
      idx = IDX_W'(offset_q) + IDX_W'(NUM_DISP - 1 - k);
      // Bounded repeated subtraction replaces a modulo; RED_N covers the worst case.
      for (int r = 0; r < RED_N; r++) begin
        if (idx >= IDX_W'(WORD_LEN)) idx = idx - IDX_W'(WORD_LEN);
      end
      ch = BLANK;
      for (int j = 0; j < WORD_LEN; j++) begin
        if (idx == IDX_W'(j)) ch = buf_q[j];
      end
      hex_d[7*k +: 7] = seg7(ch);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      offset_q <= '0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      hex_q    <= '1;
      for (int j = 0; j < WORD_LEN; j++) buf_q[j] <= BLANK;
    end else begin
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      hex_q    <= hex_d;
      buf_q    <= buf_d;
    end
  end

  assign bus.HEX    = hex_q;
  assign bus.Offset = offset_q;
  assign bus.Wrap   = wrap_q;
endmodule

// File: tb/tb_hex_word_scroller.sv
// Bench for hex_word_scroller: three configurations driven in lockstep, a behavioural
// model pushes per-cycle expectations into queues, scenario tasks pop and compare.
module tb_hex_word_scroller;
  localparam logic [6:0] S_D  = 7'b0100001;
  localparam logic [6:0] S_E  = 7'b0000110;
  localparam logic [6:0] S_1  = 7'b1111001;
  localparam logic [6:0] S_0  = 7'b1000000;
  localparam logic [6:0] S_H  = 7'b0001001;
  localparam logic [6:0] S_L  = 7'b1000111;
  localparam logic [6:0] S_P  = 7'b0001100;
  localparam logic [6:0] S_BL = 7'b1111111;

  typedef struct packed {
    logic [41:0] hex;
    logic [3:0]  off;
    logic        wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hex_word_scroller_if #(.NUM_DISP(3), .WORD_LEN(3)) ia ();
  hex_word_scroller_if #(.NUM_DISP(6), .WORD_LEN(8)) ib ();
  hex_word_scroller_if #(.NUM_DISP(6), .WORD_LEN(2)) ic ();

  hex_word_scroller #(.NUM_DISP(3), .WORD_LEN(3), .TICK_DIV(1000)) dut_a (
    .Clock(clk), .Reset(rst_a), .bus(ia));
  hex_word_scroller #(.NUM_DISP(6), .WORD_LEN(8), .TICK_DIV(4)) dut_b (
    .Clock(clk), .Reset(rst_b), .bus(ib));
  hex_word_scroller #(.NUM_DISP(6), .WORD_LEN(2), .TICK_DIV(1000)) dut_c (
    .Clock(clk), .Reset(rst_c), .bus(ic));

  int          wl_c [3] = '{3, 8, 2};
  int          nd_c [3] = '{3, 6, 6};
  int          td_c [3] = '{1000, 4, 1000};
  logic [2:0]  m_buf [3][16];
  int          m_off [3];
  int          m_cnt [3];
  logic        m_wrap [3];
  logic [41:0] m_hex [3];
  exp_t        sb_a [$];
  exp_t        sb_b [$];
  exp_t        sb_c [$];

  function automatic logic [6:0] seg_of(input logic [2:0] c);
    case (c)
      3'd0: return S_D;
      3'd1: return S_E;
      3'd2: return S_1;
      3'd3: return S_0;
      3'd4: return S_H;
      3'd5: return S_L;
      3'd6: return S_P;
      default: return S_BL;
    endcase
  endfunction

  task automatic model_one(input int id, input logic rst, input logic load,
                           input logic [47:0] word, input logic run,
                           input logic dir, input logic step);
    logic [41:0] h;
    logic        tk, ad;
    exp_t        e;
    h = '0;
    if (rst) begin
      for (int j = 0; j < 16; j++) m_buf[id][j] = 3'd7;
      m_off[id] = 0; m_cnt[id] = 0; m_wrap[id] = 1'b0;
      for (int k = 0; k < nd_c[id]; k++) h[7*k +: 7] = S_BL;
      m_hex[id] = h;
    end else begin
      for (int k = 0; k < nd_c[id]; k++)
        h[7*k +: 7] = seg_of(m_buf[id][(m_off[id] + nd_c[id] - 1 - k) % wl_c[id]]);
      tk = (m_cnt[id] == td_c[id] - 1);
      ad = run ? tk : step;
      m_cnt[id]  = tk ? 0 : m_cnt[id] + 1;
      m_wrap[id] = 1'b0;
      if (ad && !dir) begin
        m_off[id] = m_off[id] + 1;
        if (m_off[id] == wl_c[id]) begin m_off[id] = 0; m_wrap[id] = 1'b1; end
      end else if (ad && dir) begin
        m_off[id] = m_off[id] - 1;
        if (m_off[id] < 0) begin m_off[id] = wl_c[id] - 1; m_wrap[id] = 1'b1; end
      end
      if (load) begin
        for (int j = 0; j < wl_c[id]; j++) m_buf[id][j] = word[3*j +: 3];
        m_off[id] = 0; m_cnt[id] = 0; m_wrap[id] = 1'b0;
      end
      m_hex[id] = h;
    end
    e.hex  = m_hex[id];
    e.off  = 4'(m_off[id]);
    e.wrap = m_wrap[id];
    case (id)
      0: sb_a.push_back(e);
      1: sb_b.push_back(e);
      default: sb_c.push_back(e);
    endcase
  endtask

  task automatic step_clk();
    model_one(0, rst_a, ia.Load, 48'(ia.Word_In), ia.Run, ia.Dir, ia.Step);
    model_one(1, rst_b, ib.Load, 48'(ib.Word_In), ib.Run, ib.Dir, ib.Step);
    model_one(2, rst_c, ic.Load, 48'(ic.Word_In), ic.Run, ic.Dir, ic.Step);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t pop_exp(input int id);
    case (id)
      0: return sb_a.pop_front();
      1: return sb_b.pop_front();
      default: return sb_c.pop_front();
    endcase
  endfunction

  function automatic exp_t act(input int id);
    exp_t a;
    a = '0;
    case (id)
      0: begin a.hex = 42'(ia.HEX); a.off = 4'(ia.Offset); a.wrap = ia.Wrap; end
      1: begin a.hex = 42'(ib.HEX); a.off = 4'(ib.Offset); a.wrap = ib.Wrap; end
      default: begin a.hex = 42'(ic.HEX); a.off = 4'(ic.Offset); a.wrap = ic.Wrap; end
    endcase
    return a;
  endfunction

  task automatic test_reset();
    exp_t ex, ac;
    sb_a.delete(); sb_b.delete(); sb_c.delete();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; end
      step_clk();
      for (int id = 0; id < 3; id++) begin
        ex = pop_exp(id); ac = act(id);
        checks++;
        if (ac !== ex) begin
          errors++;
          $display("FAIL reset id%0d cyc%0d got hex=%h off=%0d wrap=%b want hex=%h off=%0d wrap=%b",
                   id, i, ac.hex, ac.off, ac.wrap, ex.hex, ex.off, ex.wrap);
        end
      end
    end
    checks++;
    if (ia.HEX !== 21'h1FFFFF || ib.HEX !== '1 || ia.Offset !== '0 || ib.Wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_const got a=%h b=%h off=%0d wrap=%b want all ones, 0, 0",
               ia.HEX, ib.HEX, ia.Offset, ib.Wrap);
    end
  endtask

  task automatic test_step_de1();
    logic [20:0] want [4];
    exp_t ex, ac;
    want[0] = {S_D, S_E, S_1};
    want[1] = {S_E, S_1, S_D};
    want[2] = {S_1, S_D, S_E};
    want[3] = {S_D, S_E, S_1};
    sb_a.delete();
    rst_a = 1'b1; step_clk(); rst_a = 1'b0; void'(sb_a.pop_front());
    ia.Run = 1'b0; ia.Dir = 1'b0; ia.Word_In = {3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 8; i++) begin
      ia.Load = (i == 0);
      ia.Step = (i > 0) && (i % 2 == 0);
      step_clk();
      ex = pop_exp(0); ac = act(0);
      checks++;
      if (ac !== ex) begin
        errors++;
        $display("FAIL de1_model i=%0d got hex=%h off=%0d wrap=%b want hex=%h off=%0d wrap=%b",
                 i, ac.hex, ac.off, ac.wrap, ex.hex, ex.off, ex.wrap);
      end
      if (i % 2 == 1) begin
        checks++;
        if (ia.HEX !== want[i/2]) begin
          errors++;
          $display("FAIL de1_hex i=%0d got %b want %b", i, ia.HEX, want[i/2]);
        end
      end
      if (i == 2 || i == 6) begin
        checks++;
        if (ia.Wrap !== (i == 6)) begin
          errors++;
          $display("FAIL de1_wrap i=%0d got %b want %b", i, ia.Wrap, (i == 6));
        end
      end
    end
    ia.Step = 1'b0;
  endtask

  task automatic test_auto_left();
    exp_t ex, ac;
    int   wraps;
    wraps = 0;
    sb_b.delete();
    rst_b = 1'b1; step_clk(); rst_b = 1'b0; void'(sb_b.pop_front());
    ib.Run = 1'b1; ib.Dir = 1'b0; ib.Step = 1'b0; ib.Load = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      step_clk();
      ex = pop_exp(1); ac = act(1);
      checks++;
      if (ac !== ex) begin
        errors++;
        $display("FAIL left_model c=%0d got hex=%h off=%0d wrap=%b want hex=%h off=%0d wrap=%b",
                 c, ac.hex, ac.off, ac.wrap, ex.hex, ex.off, ex.wrap);
      end
      if (ib.Wrap === 1'b1) wraps++;
      if (c % 4 == 0) begin
        checks++;
        if (ib.Offset !== 3'((c / 4) % 8)) begin
          errors++;
          $display("FAIL left_offset c=%0d got %0d want %0d", c, ib.Offset, (c / 4) % 8);
        end
      end
    end
    checks++;
    if (wraps != 2) begin
      errors++;
      $display("FAIL left_wrap_count got %0d want 2", wraps);
    end
  endtask

  task automatic test_auto_right();
    exp_t ex, ac;
    sb_b.delete();
    rst_b = 1'b1; step_clk(); rst_b = 1'b0; void'(sb_b.pop_front());
    ib.Run = 1'b1; ib.Dir = 1'b1; ib.Load = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      ib.Step = (c == 2) || (c == 5) || (c == 6);
      step_clk();
      ex = pop_exp(1); ac = act(1);
      checks++;
      if (ac !== ex) begin
        errors++;
        $display("FAIL right_model c=%0d got hex=%h off=%0d wrap=%b want hex=%h off=%0d wrap=%b",
                 c, ac.hex, ac.off, ac.wrap, ex.hex, ex.off, ex.wrap);
      end
      if (c == 4 || c == 5 || c == 8) begin
        checks++;
        if (ib.Offset !== ((c == 8) ? 3'd6 : 3'd7) || ib.Wrap !== (c == 4)) begin
          errors++;
          $display("FAIL right_const c=%0d got off=%0d wrap=%b want off=%0d wrap=%b",
                   c, ib.Offset, ib.Wrap, (c == 8) ? 6 : 7, (c == 4));
        end
      end
    end
    ib.Step = 1'b0;
  endtask

  task automatic test_load_on_tick();
    exp_t        ex, ac;
    logic [41:0] hello;
    hello = {S_H, S_E, S_L, S_L, S_0, S_BL};
    sb_b.delete();
    rst_b = 1'b1; step_clk(); rst_b = 1'b0; void'(sb_b.pop_front());
    ib.Run = 1'b1; ib.Dir = 1'b0; ib.Step = 1'b0;
    ib.Word_In = {3'd7, 3'd7, 3'd7, 3'd3, 3'd5, 3'd5, 3'd1, 3'd4};
    for (int c = 1; c <= 32; c++) begin
      ib.Load = (c == 24);
      step_clk();
      ex = pop_exp(1); ac = act(1);
      checks++;
      if (ac !== ex) begin
        errors++;
        $display("FAIL load_model c=%0d got hex=%h off=%0d wrap=%b want hex=%h off=%0d wrap=%b",
                 c, ac.hex, ac.off, ac.wrap, ex.hex, ex.off, ex.wrap);
      end
      if (c == 20 || c == 24 || c == 27 || c == 28) begin
        checks++;
        if (ib.Offset !== ((c == 20) ? 3'd5 : (c == 28) ? 3'd1 : 3'd0)) begin
          errors++;
          $display("FAIL load_offset c=%0d got %0d", c, ib.Offset);
        end
      end
      if (c == 24 || c == 25) begin
        checks++;
        if (ib.HEX !== ((c == 24) ? 42'h3FFFFFFFFFF : hello)) begin
          errors++;
          $display("FAIL load_hex c=%0d got %h want %h", c, ib.HEX,
                   (c == 24) ? 42'h3FFFFFFFFFF : hello);
        end
      end
    end
    ib.Load = 1'b0;
  endtask

  task automatic test_he_repeat();
    exp_t        ex, ac;
    logic [41:0] he, eh;
    he = {S_H, S_E, S_H, S_E, S_H, S_E};
    eh = {S_E, S_H, S_E, S_H, S_E, S_H};
    sb_c.delete();
    rst_c = 1'b1; step_clk(); rst_c = 1'b0; void'(sb_c.pop_front());
    ic.Run = 1'b0; ic.Dir = 1'b0; ic.Word_In = {3'd1, 3'd4};
    for (int i = 0; i < 6; i++) begin
      ic.Load = (i == 0);
      ic.Step = (i == 2) || (i == 4);
      step_clk();
      ex = pop_exp(2); ac = act(2);
      checks++;
      if (ac !== ex) begin
        errors++;
        $display("FAIL he_model i=%0d got hex=%h off=%0d wrap=%b want hex=%h off=%0d wrap=%b",
                 i, ac.hex, ac.off, ac.wrap, ex.hex, ex.off, ex.wrap);
      end
      if (i % 2 == 1) begin
        checks++;
        if (ic.HEX !== ((i == 3) ? eh : he)) begin
          errors++;
          $display("FAIL he_hex i=%0d got %h want %h", i, ic.HEX, (i == 3) ? eh : he);
        end
      end
      if (i == 2 || i == 4) begin
        checks++;
        if (ic.Wrap !== (i == 4)) begin
          errors++;
          $display("FAIL he_wrap i=%0d got %b want %b", i, ic.Wrap, (i == 4));
        end
      end
    end
    ic.Step = 1'b0; ic.Load = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t ex, ac;
    sb_a.delete(); sb_b.delete();
    for (int c = 0; c < 300; c++) begin
      ia.Step    = 1'($urandom_range(0, 1));
      ia.Dir     = 1'($urandom_range(0, 1));
      ia.Load    = ($urandom_range(0, 15) == 0);
      ia.Word_In = 9'($urandom());
      ib.Run     = ($urandom_range(0, 3) != 0);
      ib.Dir     = 1'($urandom_range(0, 1));
      ib.Step    = 1'($urandom_range(0, 1));
      ib.Load    = ($urandom_range(0, 31) == 0);
      ib.Word_In = 24'($urandom());
      rst_b      = ($urandom_range(0, 63) == 0);
      step_clk();
      for (int id = 0; id < 2; id++) begin
        ex = pop_exp(id); ac = act(id);
        checks++;
        if (ac !== ex) begin
          errors++;
          $display("FAIL b2b id%0d c=%0d got hex=%h off=%0d wrap=%b want hex=%h off=%0d wrap=%b",
                   id, c, ac.hex, ac.off, ac.wrap, ex.hex, ex.off, ex.wrap);
        end
      end
    end
    rst_b = 1'b0; ia.Load = 1'b0; ib.Load = 1'b0; ia.Step = 1'b0; ib.Step = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ia.Load = 1'b0; ia.Word_In = '0; ia.Run = 1'b0; ia.Dir = 1'b0; ia.Step = 1'b0;
    ib.Load = 1'b0; ib.Word_In = '0; ib.Run = 1'b0; ib.Dir = 1'b0; ib.Step = 1'b0;
    ic.Load = 1'b0; ic.Word_In = '0; ic.Run = 1'b0; ic.Dir = 1'b0; ic.Step = 1'b0;
    #1;
    test_reset();
    test_step_de1();
    test_auto_left();
    test_auto_right();
    test_load_on_tick();
    test_he_repeat();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
